// File: rtl/dma_pkg.sv
// Shared codes and FSM state type for the DMA load scheduler.
package dma_pkg;

    localparam logic [2:0] TYPE_NONE    = 3'd0;
    localparam logic [2:0] TYPE_INPUT   = 3'd1;
    localparam logic [2:0] TYPE_PT_EVEN = 3'd2;
    localparam logic [2:0] TYPE_PT_ODD  = 3'd3;
    localparam logic [2:0] TYPE_V       = 3'd4;
    localparam logic [2:0] TYPE_Z       = 3'd5;
    localparam logic [2:0] TYPE_BIAS    = 3'd6;

    localparam logic [1:0] BUF_IDLE = 2'b00;
    localparam logic [1:0] BUF_RD   = 2'b01;
    localparam logic [1:0] BUF_WR   = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StDrain
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the last winner + 1 with wrap; pointer moves on advance.
module rr_arbiter #(
    parameter int unsigned NUM_REQ   = 6,
    parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk_h,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 advance,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] idx;

    always_ff @(posedge clk_h) begin
        if (rst) begin
            ptr_q <= IDX_WIDTH'(NUM_REQ - 1);
        end else if (advance && grant_valid) begin
            ptr_q <= grant_idx;
        end
    end

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_load_scheduler.sv
// Grants one RAM loader at a time and sequences its lines through the DMA line buffer.
module dma_load_scheduler
    import dma_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 6,
    parameter int unsigned MEM_ADDR_WIDTH = 6,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned WORDS_PER_LINE = 16,
    parameter int unsigned TIMEOUT        = 64
) (
    input  logic                          clk_h,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_lines,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    input  logic                          line_valid,
    output logic                          line_pop,
    output logic [1:0]                    buf_enable,
    output logic [MEM_ADDR_WIDTH-1:0]     buf_addr,
    output logic [2:0]                    buf_type,
    output logic                          buf_selecter,
    input  logic                          buf_ready,
    input  logic                          buf_to_ram_ready,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned DrnW = $clog2(WORDS_PER_LINE + 1);

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]      lines_left_q, lines_left_d;
    logic [2:0]                type_q, type_d;
    logic [NUM_REQ-1:0]        owner_q, owner_d;
    logic [TmoW-1:0]           tmo_q, tmo_d;
    logic [DrnW-1:0]           drain_q, drain_d;
    logic                      zero_pend_q, zero_pend_d;

    logic [NUM_REQ-1:0]        ack_q, ack_d, done_q, done_d;
    logic                      line_pop_q, line_pop_d;
    logic [1:0]                buf_enable_q, buf_enable_d;
    logic [MEM_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [2:0]                buf_type_q, buf_type_d;
    logic                      buf_selecter_q, buf_selecter_d;
    logic                      err_q, err_d;

    logic [NUM_REQ-1:0]        grant;
    logic [IdxW-1:0]           grant_idx;
    logic                      grant_valid;
    logic                      advance;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IdxW)
    ) u_arb (
        .clk_h       (clk_h),
        .rst         (rst),
        .req         (req),
        .advance     (advance),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        lines_left_d   = lines_left_q;
        type_d         = type_q;
        owner_d        = owner_q;
        tmo_d          = tmo_q;
        drain_d        = drain_q;
        zero_pend_d    = 1'b0;
        ack_d          = '0;
        done_d         = '0;
        line_pop_d     = 1'b0;
        buf_enable_d   = BUF_IDLE;
        buf_selecter_d = 1'b0;
        err_d          = err_q;
        advance        = 1'b0;

        case (state_q)
            StIdle: begin
                // The done_q check guarantees a bubble cycle between back-to-back jobs.
                if (zero_pend_q) begin
                    done_d = owner_q;
                end else if (grant_valid && (done_q == '0)) begin
                    advance      = 1'b1;
                    ack_d        = grant;
                    owner_d      = grant;
                    cur_addr_d   = req_base[grant_idx*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                    lines_left_d = req_lines[grant_idx*LEN_WIDTH +: LEN_WIDTH];
                    type_d       = 3'(grant_idx) + 3'd1;
                    if (lines_left_d == '0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (line_valid && buf_ready) begin
                    buf_enable_d   = BUF_WR;
                    buf_selecter_d = 1'b1;
                    tmo_d          = '0;
                    state_d        = StWaitAck;
                end
            end
            StWaitAck: begin
                buf_selecter_d = 1'b1;
                if (buf_to_ram_ready) begin
                    line_pop_d     = 1'b1;
                    drain_d        = '0;
                    buf_selecter_d = 1'b0;
                    state_d        = StDrain;
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    err_d          = 1'b1;
                    done_d         = owner_q;
                    buf_selecter_d = 1'b0;
                    state_d        = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StDrain: begin
                if (drain_q == DrnW'(WORDS_PER_LINE - 1)) begin
                    lines_left_d = lines_left_q - LEN_WIDTH'(1);
                    cur_addr_d   = cur_addr_q + MEM_ADDR_WIDTH'(WORDS_PER_LINE);
                    if (lines_left_q == LEN_WIDTH'(1)) begin
                        done_d  = owner_q;
                        state_d = StIdle;
                    end else begin
                        state_d = StIssue;
                    end
                end else begin
                    drain_d = drain_q + DrnW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        buf_addr_d = (state_d == StIdle) ? '0 : cur_addr_d;
        buf_type_d = (state_d == StIdle) ? TYPE_NONE : type_d;
    end

    always_ff @(posedge clk_h) begin
        if (rst) begin
            state_q        <= StIdle;
            cur_addr_q     <= '0;
            lines_left_q   <= '0;
            type_q         <= TYPE_NONE;
            owner_q        <= '0;
            tmo_q          <= '0;
            drain_q        <= '0;
            zero_pend_q    <= 1'b0;
            ack_q          <= '0;
            done_q         <= '0;
            line_pop_q     <= 1'b0;
            buf_enable_q   <= BUF_IDLE;
            buf_addr_q     <= '0;
            buf_type_q     <= TYPE_NONE;
            buf_selecter_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            lines_left_q   <= lines_left_d;
            type_q         <= type_d;
            owner_q        <= owner_d;
            tmo_q          <= tmo_d;
            drain_q        <= drain_d;
            zero_pend_q    <= zero_pend_d;
            ack_q          <= ack_d;
            done_q         <= done_d;
            line_pop_q     <= line_pop_d;
            buf_enable_q   <= buf_enable_d;
            buf_addr_q     <= buf_addr_d;
            buf_type_q     <= buf_type_d;
            buf_selecter_q <= buf_selecter_d;
            err_q          <= err_d;
        end
    end

    assign ack          = ack_q;
    assign done         = done_q;
    assign line_pop     = line_pop_q;
    assign buf_enable   = buf_enable_q;
    assign buf_addr     = buf_addr_q;
    assign buf_type     = buf_type_q;
    assign buf_selecter = buf_selecter_q;
    assign busy         = (state_q != StIdle);
    assign err          = err_q;

endmodule

// File: doc/dma_load_scheduler.md
Name: dma_load_scheduler

Overview:
- Arbitrates up to six on-chip RAM loaders (input, point_even, point_odd, v_ram, z_ram, bias_ram) for the single DMA line buffer.
- For the granted loader, sequences a multi-line job: presents each 256-bit line to the buffer, waits for the buffer's to-RAM handshake, then lets the 16-word drain finish before moving to the next line.
- Sits between the external-memory line fetcher and the DMA buffer.

Parameters:
- NUM_REQ, 6, number of requesters; fixed by the 3-bit RAM-select code.
- MEM_ADDR_WIDTH, 6, width of the buffer line address.
- LEN_WIDTH, 8, width of the per-job line count.
- WORDS_PER_LINE, 16, 16-bit words per 256-bit line; equals the drain length.
- TIMEOUT, 64, maximum cycles to wait for buf_to_ram_ready.

Ports:
- clk_h  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester job request; level signal.
- req_base  in  NUM_REQ*MEM_ADDR_WIDTH  job start address; slice i belongs to requester i.
- req_lines  in  NUM_REQ*LEN_WIDTH  number of lines in the job; slice i belongs to requester i.
- ack  out  NUM_REQ  one-cycle pulse when the job is accepted.
- done  out  NUM_REQ  one-cycle pulse when the job finishes or aborts.
- line_valid  in  1  fetcher has a 256-bit line on the buffer data bus.
- line_pop  out  1  one-cycle pulse; the line has been consumed.
- buf_enable  out  2  buffer command: 00 idle, 10 write.
- buf_addr  out  MEM_ADDR_WIDTH  line address to the buffer.
- buf_type  out  3  RAM select code.
- buf_selecter  out  1  buffer capture qualifier.
- buf_ready  in  1  buffer idle/ready.
- buf_to_ram_ready  in  1  buffer has captured the line and started its drain.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk_h edge):
  - FSM goes to IDLE; all outputs go to 0; round-robin pointer goes to NUM_REQ-1.
  - Reset mid-job abandons the job with no done pulse.
- Code mapping: requester i uses buf_type = i+1, i.e. 001 through 110. 000 is emitted only when idle.
- FSM states: IDLE, ISSUE, WAIT_ACK, DRAIN.
- IDLE:
  - If any req bit is set, grant round-robin, searching from pointer+1 with wrap.
  - On grant: latch base into cur_addr, lines into lines_left, and latch the type; pulse ack[g]; set pointer to g.
  - If the latched lines value is 0: pulse done[g] in the next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
  - The grant decision is registered, so ack appears one cycle after req is sampled.
- ISSUE:
  - Wait for line_valid=1 and buf_ready=1.
  - Then drive, for exactly one cycle: buf_enable=10, buf_addr=cur_addr, buf_type=latched type, buf_selecter=1.
  - Clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - Hold buf_selecter=1, buf_addr, and buf_type; buf_enable=00.
  - On buf_to_ram_ready=1: pulse line_pop, clear the drain counter, go to DRAIN.
  - If the counter reaches TIMEOUT-1 without the handshake: set err, pulse done[g], go to IDLE. The job is aborted.
  - If the handshake and the final timeout cycle coincide, the handshake wins.
- DRAIN:
  - buf_selecter=0.
  - Count WORDS_PER_LINE cycles. On the last count, decrement lines_left and set cur_addr = cur_addr + WORDS_PER_LINE, modulo 2^MEM_ADDR_WIDTH (wraps silently).
  - If lines_left becomes 0: pulse done[g] and go to IDLE. Otherwise go to ISSUE.
- Request handling:
  - req dropping after ack has no effect.
  - req held after done re-arbitrates in IDLE, with one bubble cycle minimum between jobs.
  - Changes to req_base or req_lines after ack are ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package dma_pkg:
  - RAM-select codes: TYPE_NONE=0, TYPE_INPUT=1, TYPE_PT_EVEN=2, TYPE_PT_ODD=3, TYPE_V=4, TYPE_Z=5, TYPE_BIAS=6.
  - Buffer command codes: BUF_IDLE=00, BUF_RD=01, BUF_WR=10.
  - FSM state enum.
- Sub-module rr_arbiter: parameterized NUM_REQ round-robin arbiter with registered pointer, one-hot grant, and a grant-valid output.

Test Plan:
- Single job: req[0]=1, base=0, lines=2, line_valid=1, buffer model asserts to_ram_ready 2 cycles after the write.
  - Expect ack[0] at cycle 1.
  - Expect two buf_enable=10 pulses with buf_addr=0 and then 16, buf_type=001.
  - Expect two line_pop pulses and done[0] after the second drain; busy low after that.
- Fairness: req[1] and req[4] held high, lines=1 each.
  - Grants alternate 1,4,1,4; buf_type alternates 010 and 101.
- Zero length: req[5]=1 with lines=0.
  - Expect ack[5], then done[5] the next cycle; no buf_enable activity.
- Timeout: buffer model never asserts to_ram_ready.
  - After 64 cycles in WAIT_ACK: err=1, done pulses, FSM in IDLE.
  - A following good job still completes while err stays 1.
- Wrap and back-pressure: base=48, lines=2.
  - Expect addresses 48 then 0.
  - line_valid low for 5 cycles holds the FSM in ISSUE with no write pulse.
- Reset mid-drain: assert rst in DRAIN.
  - All outputs 0 the next cycle; no done pulse.
  - A new request after reset is served from pointer wrap, so requester 0 wins first.
